wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//   Consumer end of the MEM/WB pipeline register: the write-back stage plus the integer register file.
//   - Selects the write-back value from ALU result, load data or PC+4, using the wD_sel field carried through MEM/WB.
//   - Commits the value to the 32x32 register file. The file serves the two decode-stage read ports.
//   - Keeps an instructions-retired counter and the PC of the last retired instruction.
// PARAMETERS
//   DATA_W     32  register / data width
//   NREG       32  number of architectural registers (x0 hardwired to zero)
//   ADDR_W     5   register index width, log2(NREG)
//   INSTRET_W  64  width of retired-instruction counter
// PORTS
//   clk             in   1          clock, rising edge
//   reset           in   1          asynchronous, active-low
//   wb_bubble_i     in   1          1 = slot holds a bubble (no commit, no retire)
//   wb_inst_i       in   32         instruction word; rd = wb_inst_i[11:7]
//   wb_wD_sel_i     in   2          write-back source select
//   wb_pc_i         in   32         PC of instruction in WB
//   wb_pc4_i        in   32         PC+4 of instruction in WB
//   wb_C_i          in   DATA_W     ALU result
//   wb_WriteData_i  in   DATA_W     load data from memory
//   wb_RegWrite_i   in   1          instruction writes rd
//   rs1_addr_i      in   ADDR_W     decode read port 1 index
//   rs2_addr_i      in   ADDR_W     decode read port 2 index
//   rs1_data_o      out  DATA_W     read port 1 data (combinational)
//   rs2_data_o      out  DATA_W     read port 2 data (combinational)
//   wb_data_o       out  DATA_W     selected write-back value, to EX forwarding mux (combinational)
//   wb_rd_o         out  ADDR_W     destination index of WB instruction (combinational)
//   wb_we_o         out  1          effective register write this cycle (combinational)
//   instret_o       out  INSTRET_W  retired-instruction count (registered)
//   last_pc_o       out  32         PC of most recent retired instruction (registered)
// BEHAVIOUR
//   - Source mux (wb_data_o): wD_sel 2'b00 = wb_C_i; 2'b01 = wb_WriteData_i; 2'b10 = wb_pc4_i; 2'b11 = wb_C_i (reserved).
//   - wb_we_o = wb_RegWrite_i & ~wb_bubble_i & (rd != 0).
//   - Write: on posedge clk with wb_we_o = 1, regs[rd] <= wb_data_o. Latency is one edge.
//   - x0: never written; any read of index 0 returns 0 regardless of bypass.
//   - Read ports: combinational from the array, two independent ports. rs1 == rs2 is legal.
//   - Retire: every cycle with wb_bubble_i = 0 is a retire, including instructions with RegWrite = 0 (stores, branches).
//     - instret_o <= instret_o + 1 on each retire. Wraps all-ones -> 0 with no flag.
//     - last_pc_o <= wb_pc_i on each retire. Both hold on a bubble.
//   - Reset (reset = 0, asynchronous, active-low, effective mid-operation):
//     - All registers clear to 0; instret_o = 0; last_pc_o = 0.
//     - A write presented on the same edge as reset assertion is discarded.
//     - The first edge after reset deasserts behaves normally.
//     - MEM/WB resets its bubble to 1, so no spurious retire occurs after reset.
//   - Combinational outputs follow the inputs at all times, including during reset.
//     wb_we_o is forced to 0 while reset = 0.
//   - There is no state machine. Sequential state is limited to the register array, the counter and last_pc.
// CONFIGURATION
//   WB_BYPASS_EN defined: write-through read.
//     - If wb_we_o = 1 and rsN_addr_i == wb_rd_o (nonzero), rsN_data_o = wb_data_o in the same cycle.
//     - Decode sees the WB value without a stall.
//   WB_BYPASS_EN undefined: reads return the array contents before the pending write (old value).
//     - The hazard unit must stall decode one cycle, or forward externally, on a WB/ID RAW match.
// TESTING
//   1 Reset: drive reset=0 with random inputs -> rs1/rs2 = 0 for all indices, instret_o = 0, last_pc_o = 0.
//   2 Source select: rd=5, RegWrite=1, bubble=0; C=0x11, WriteData=0x22, pc4=0x104.
//     - wD_sel=00/01/10 -> after the edge, regs[5] reads 0x11 / 0x22 / 0x104 respectively.
//   3 Suppression:
//     - bubble=1, RegWrite=1, rd=7, C=0xDEAD -> x7 unchanged, instret unchanged.
//     - rd=0, C=0xBEEF -> x0 still reads 0.
//   4 RAW same cycle: rd=3, C=0xA5A5, rs1_addr=3 during the write cycle.
//     - With WB_BYPASS_EN: rs1_data = 0xA5A5 before the edge.
//     - Without WB_BYPASS_EN: old x3 before the edge, 0xA5A5 after.
//   5 Retire count:
//     - 10 non-bubble cycles (4 with RegWrite=0), 3 bubbles, last pc=0x200 -> instret_o = 10, last_pc_o = 0x200.
//     - Force the counter to all-ones, retire once -> instret_o = 0.
//   6 Reset mid-stream: write x9 = 0x1234, then pulse reset low between edges.
//     - x9 reads 0 immediately; instret_o = 0.
//     - The next write after release commits normally.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 integer register file.
// Selects the write-back value, commits it to the register file, serves two
// decode read ports, and tracks the retired-instruction count and last retired PC.
// Optional feature: define WB_BYPASS_EN for write-through reads of the WB value.
module wb_regfile #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREG      = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_bubble_i,
    input  logic [31:0]          wb_inst_i,
    input  logic [1:0]           wb_wD_sel_i,
    input  logic [31:0]          wb_pc_i,
    input  logic [31:0]          wb_pc4_i,
    input  logic [DATA_W-1:0]    wb_C_i,
    input  logic [DATA_W-1:0]    wb_WriteData_i,
    input  logic                 wb_RegWrite_i,
    input  logic [ADDR_W-1:0]    rs1_addr_i,
    input  logic [ADDR_W-1:0]    rs2_addr_i,
    output logic [DATA_W-1:0]    rs1_data_o,
    output logic [DATA_W-1:0]    rs2_data_o,
    output logic [DATA_W-1:0]    wb_data_o,
    output logic [ADDR_W-1:0]    wb_rd_o,
    output logic                 wb_we_o,
    output logic [INSTRET_W-1:0] instret_o,
    output logic [31:0]          last_pc_o
);

    logic [DATA_W-1:0] regs [NREG];
    logic              retire;
    logic              unused_inst;

    // Only the rd field of the instruction word matters here
    assign unused_inst = ^{wb_inst_i[31:12], wb_inst_i[6:0]};

    assign wb_rd_o = ADDR_W'(wb_inst_i[11:7]);
    assign retire  = ~wb_bubble_i;

    // Commit only real, writing, non-x0 instructions; held off while in reset
    assign wb_we_o = reset & wb_RegWrite_i & ~wb_bubble_i & (wb_rd_o != '0);

    // Write-back source select; encoding 2'b11 is reserved and aliases the ALU result
    always_comb begin
        wb_data_o = wb_C_i;
        case (wb_wD_sel_i)
            2'b00:   wb_data_o = wb_C_i;
            2'b01:   wb_data_o = wb_WriteData_i;
            2'b10:   wb_data_o = DATA_W'(wb_pc4_i);
            default: wb_data_o = wb_C_i;
        endcase
    end

    // Read port 1: x0 reads zero, optional write-through of the pending WB value
    always_comb begin
        rs1_data_o = regs[rs1_addr_i];
        if (rs1_addr_i == '0) begin
            rs1_data_o = '0;
        end
`ifdef WB_BYPASS_EN
        else if (wb_we_o && (rs1_addr_i == wb_rd_o)) begin
            rs1_data_o = wb_data_o;
        end
`endif
    end

    // Read port 2: same rules as port 1
    always_comb begin
        rs2_data_o = regs[rs2_addr_i];
        if (rs2_addr_i == '0) begin
            rs2_data_o = '0;
        end
`ifdef WB_BYPASS_EN
        else if (wb_we_o && (rs2_addr_i == wb_rd_o)) begin
            rs2_data_o = wb_data_o;
        end
`endif
    end

    // Register array: cleared by reset, one write port from WB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we_o) begin
            regs[wb_rd_o] <= wb_data_o;
        end
    end

    // Retire bookkeeping: counter wraps silently, both hold on a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_o <= '0;
            last_pc_o <= '0;
        end else if (retire) begin
            instret_o <= instret_o + INSTRET_W'(1);
            last_pc_o <= wb_pc_i;
        end
    end

endmodule
